jk_counter_ctrl: RTL
====================

Name: jk_counter_ctrl

Overview:
- Sequencer for a bank of WIDTH JK flip-flop stages that together form a modulo-MOD synchronous counter.
- Accepts clear/load/run/pause commands over a valid/ready handshake and computes per-stage J/K drive every cycle.
- Tracks a programmed step count and reports terminal count (wrap) and run completion.
- Sits between a lab control front-end (switch/key debouncer or host register) and the display/decoder path.

Parameters:
- WIDTH, 4, number of JK stages / counter bits (2..16)
- MOD, 10, count modulus; legal range 2..2**WIDTH; q cycles 0..MOD-1

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_op  in  2  00 clear, 01 load, 10 run, 11 pause
- cmd_data  in  WIDTH  load: value; run: step count (0 = continuous)
- up_dn  in  1  1 = count up, 0 = count down; sampled at every step edge
- q  out  WIDTH  counter value (outputs of the JK stages)
- busy  out  1  high in RUN
- tc  out  1  one-cycle pulse after a wrap edge
- done  out  1  one-cycle pulse on run completion
- err  out  1  one-cycle pulse on an illegal command

Behaviour:
- Reset, asynchronous: q=0, state IDLE, busy=0, tc=0, done=0, err=0. cmd_ready=1 immediately after rst_n deasserts.
- Accept occurs on a rising edge with cmd_valid && cmd_ready. cmd_ready=1 in IDLE and RUN, 0 in DONE.
- FSM states: IDLE, RUN, DONE.
- IDLE + clear:
  - All stages driven J=0, K=1; q=0 at the accept edge.
  - Stays in IDLE.
- IDLE + load:
  - Each stage i is driven J=v[i], K=~v[i], where v = min(cmd_data, MOD-1).
  - q=v at the accept edge; stays in IDLE.
- IDLE + run:
  - steps_left <= cmd_data; go to RUN. q is unchanged at the accept edge.
  - First step occurs at the next edge.
- IDLE + pause: no effect; no err.
- RUN, one step per edge:
  - Up: stage i gets J=K=AND(q[i-1:0]). If q==MOD-1, all stages are forced to J=0, K=1 (q becomes 0) and tc pulses.
  - Down: stage i gets J=K=AND(~q[i-1:0]). If q==0, the load pattern MOD-1 is forced and tc pulses.
- RUN, step counting:
  - If steps_left != 0, it decrements each step. The step that reaches 0 moves the FSM to DONE.
  - run with N>0 gives exactly N steps at edges E1..EN after accept edge E0. done=1 in the cycle after EN; the FSM returns to IDLE at EN+1.
  - run with 0 counts until pause or clear.
- RUN + pause: no step at that edge; q holds; go to IDLE; no done.
- RUN + clear: q=0; go to IDLE; no done; no tc.
- RUN + load or run: command ignored; err=1 next cycle; counting continues.
- Simultaneous events:
  - Last step with pause: pause wins; the step is not taken; IDLE; no done.
  - Last step with clear: clear wins.
  - Wrap on the last step: tc and done both assert in the same cycle.
- tc, done and err are registered, high for exactly one cycle.
- Reset asserted mid-run: immediate return to the reset state; no done.

Optional Feature:
- Macro JKC_DOWN_COUNT_EN.
- Defined: up_dn is honoured as described above.
- Undefined: up_dn is ignored and the counter always counts up. The down-count J/K logic and the MOD-1 wrap-load path are not synthesised.

Decomposition:
- Package jkc_pkg holds:
  - cmd_op encodings: JKC_OP_CLEAR, JKC_OP_LOAD, JKC_OP_RUN, JKC_OP_PAUSE.
  - FSM state encoding: JKC_IDLE, JKC_RUN, JKC_DONE.
- Sub-module jk_stage: one rising-edge JK flip-flop with asynchronous active-low clear, instantiated WIDTH times.
- The controller never writes q directly; it only drives J/K into the jk_stage instances.

Test Plan (WIDTH=4, MOD=10):
- Reset, then load 7 -> q=7 after the accept edge; cmd_ready=1; busy=0.
- Load 13 -> q=9 (clamped); no err.
- Load 8, up_dn=1, run 3 -> q=9, 0, 1 on E1..E3. tc=1 in the cycle after E2. done=1 after E3; the FSM is back in IDLE one edge later.
- Load 1, up_dn=0, run 0, pause after 4 steps -> q=1, 0, 9, 8, 7. tc after the 1->0->9 wrap edge. busy drops; done never asserted. Without JKC_DOWN_COUNT_EN the same run gives q=1, 2, 3, 4, 5.
- During RUN, issue load 5 -> err=1 for one cycle; q keeps counting. Then clear -> q=0, IDLE, no done.
- Assert rst_n low mid-run with q=6 -> q=0 immediately (asynchronous); busy=0; no done or tc after rst_n release.

Source files
------------

// File: rtl/jkc_pkg.sv
// Shared command and state encodings for the JK counter sequencer.
package jkc_pkg;

    typedef enum logic [1:0] {
        JKC_OP_CLEAR = 2'b00,
        JKC_OP_LOAD  = 2'b01,
        JKC_OP_RUN   = 2'b10,
        JKC_OP_PAUSE = 2'b11
    } jkc_op_e;

    typedef enum logic [1:0] {
        JKC_IDLE = 2'd0,
        JKC_RUN  = 2'd1,
        JKC_DONE = 2'd2
    } jkc_state_e;

endpackage

// File: rtl/jk_stage.sv
// Single rising-edge JK flip-flop with asynchronous active-low clear.
module jk_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command sequencer driving a bank of JK stages as a modulo-MOD counter.
// Down counting is built only when JKC_DOWN_COUNT_EN is defined.
module jk_counter_ctrl
    import jkc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    jkc_state_e       state;
    jkc_op_e          op;
    logic [WIDTH-1:0] steps_left;
    logic [WIDTH-1:0] j_drive;
    logic [WIDTH-1:0] k_drive;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] tog_up;
    logic             all_ones;
    logic             accept;
    logic             step_en;
    logic             wrap;

    assign op        = jkc_op_e'(cmd_op);
    assign cmd_ready = (state != JKC_DONE);
    assign busy      = (state == JKC_RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign load_val  = (cmd_data > MAX_VAL) ? MAX_VAL : cmd_data;
    assign step_en   = (state == JKC_RUN) &&
                       !(accept && (op == JKC_OP_CLEAR || op == JKC_OP_PAUSE));

`ifdef JKC_DOWN_COUNT_EN
    logic [WIDTH-1:0] tog_dn;
    logic             all_zeros;

    assign wrap = up_dn ? (q == MAX_VAL) : (q == '0);

    always_comb begin
        tog_dn    = '0;
        all_zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog_dn[i] = all_zeros;
            all_zeros = all_zeros & ~q[i];
        end
    end
`else
    logic unused_up_dn;

    assign unused_up_dn = up_dn;
    assign wrap         = (q == MAX_VAL);
`endif

    always_comb begin
        tog_up   = '0;
        all_ones = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog_up[i] = all_ones;
            all_ones  = all_ones & q[i];
        end
    end

    // J=K=0 holds every stage; clear/load/step only ever steer the J/K inputs.
    always_comb begin
        j_drive = '0;
        k_drive = '0;
        if (accept && op == JKC_OP_CLEAR) begin
            k_drive = '1;
        end else if (state == JKC_IDLE && accept && op == JKC_OP_LOAD) begin
            j_drive = load_val;
            k_drive = ~load_val;
        end else if (step_en) begin
`ifdef JKC_DOWN_COUNT_EN
            if (!up_dn) begin
                if (q == '0) begin
                    j_drive = MAX_VAL;
                    k_drive = ~MAX_VAL;
                end else begin
                    j_drive = tog_dn;
                    k_drive = tog_dn;
                end
            end else
`endif
            if (q == MAX_VAL) begin
                k_drive = '1;
            end else begin
                j_drive = tog_up;
                k_drive = tog_up;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= JKC_IDLE;
            steps_left <= '0;
            tc         <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            tc   <= step_en && wrap;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                JKC_IDLE: begin
                    if (accept && op == JKC_OP_RUN) begin
                        steps_left <= cmd_data;
                        state      <= JKC_RUN;
                    end
                end
                JKC_RUN: begin
                    if (accept && (op == JKC_OP_CLEAR || op == JKC_OP_PAUSE)) begin
                        state <= JKC_IDLE;
                    end else begin
                        if (accept) begin
                            err <= 1'b1;
                        end
                        // A zero step count means free-running until stopped.
                        if (steps_left != '0) begin
                            steps_left <= steps_left - WIDTH'(1);
                            if (steps_left == WIDTH'(1)) begin
                                state <= JKC_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                JKC_DONE: state <= JKC_IDLE;
                default:  state <= JKC_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        jk_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_drive[i]),
            .k     (k_drive[i]),
            .q     (q[i])
        );
    end

endmodule
